// File: rtl/pipes_list_if.sv
// Handshake bundle between the game CPU and the pipes list.
// The master side is the CPU; the slave side is the list itself.
interface pipes_list_if #(
  parameter int COUNT_WIDTH = 5
);
  logic [COUNT_WIDTH-1:0] count;
  logic                   insert_en;
  logic [22:0]            insert_data;
  logic                   iter_start;
  logic                   iter_done;
  logic [22:0]            iter_in;
  logic [22:0]            iter_out;
  logic                   iter_remove;

  modport master (
    output insert_en, insert_data, iter_start, iter_in, iter_remove,
    input  count, iter_done, iter_out
  );

  modport slave (
    input  insert_en, insert_data, iter_start, iter_in, iter_remove,
    output count, iter_done, iter_out
  );
endinterface

// File: rtl/pipes_list.sv
// Bounded ordered list of pipe records {x[11:0] signed, y[10:0]} kept as a circular FIFO.
// Iteration pops the head and pushes the rewritten element at the tail, preserving order.
module pipes_list #(
  parameter int CAPACITY    = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  pipes_list_if.slave   bus
);
  localparam int PTR_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

  typedef enum logic {IDLE, ITER} state_t;

  state_t                 state_q, state_d;
  logic [22:0]            mem [CAPACITY];
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [COUNT_WIDTH-1:0] count_q, remaining_q;
  logic [22:0]            out_q;

  logic                   full, last;
  logic                   do_insert, do_commit, do_push;
  logic [22:0]            push_data;
  logic [COUNT_WIDTH-1:0] start_count;
  logic                   iter_done;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAPACITY - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full        = (count_q == COUNT_WIDTH'(CAPACITY));
    last        = (remaining_q == COUNT_WIDTH'(1));
    do_insert   = (state_q == IDLE) && bus.insert_en && !full;
    do_commit   = (state_q == ITER) && !bus.iter_start;
    do_push     = do_insert || (do_commit && !bus.iter_remove);
    push_data   = do_insert ? bus.insert_data : bus.iter_in;
    // An insert in the same cycle as iter_start is counted into the new pass
    start_count = count_q + COUNT_WIDTH'(do_insert);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ce) begin
      unique case (state_q)
        IDLE: if (bus.iter_start && (start_count != '0)) state_d = ITER;
        ITER: if (do_commit && last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    iter_done = (state_q == IDLE) || last;
  end

  // Storage is left uncleared by reset; the async read sees pre-write contents,
  // so a full-list pop and push on the same slot reads before it writes.
  always_ff @(posedge clk) begin
    if (rst && ce && do_push) mem[tail_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      out_q       <= '0;
    end else if (ce) begin
      if (do_push)   tail_q <= wrap_inc(tail_q);
      if (do_commit) head_q <= wrap_inc(head_q);
      unique case (state_q)
        IDLE: begin
          if (do_insert) count_q <= count_q + COUNT_WIDTH'(1);
          if (bus.iter_start) begin
            remaining_q <= start_count;
            if (count_q != '0)  out_q <= mem[head_q];
            else if (do_insert) out_q <= bus.insert_data;
            else                out_q <= '0;
          end
        end
        ITER: begin
          if (bus.iter_start) begin
            remaining_q <= count_q;
            out_q       <= mem[head_q];
          end else begin
            if (bus.iter_remove) count_q <= count_q - COUNT_WIDTH'(1);
            if (last) begin
              remaining_q <= '0;
            end else begin
              remaining_q <= remaining_q - COUNT_WIDTH'(1);
              out_q       <= mem[wrap_inc(head_q)];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count     = count_q;
  assign bus.iter_out  = out_q;
  assign bus.iter_done = iter_done;
endmodule

// File: tb/tb_pipes_list.sv
// Bench for pipes_list: directed scenarios plus random traffic against a queue-based list model.
module tb_pipes_list;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  int total = 0;
  int bad   = 0;

  pipes_list_if #(.COUNT_WIDTH(5)) bus ();

  pipes_list #(.CAPACITY(16), .COUNT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: the list is a plain queue; a pass is "pop front, maybe push back"
  logic [22:0] q [$];
  bit          m_active = 1'b0;
  int          m_rem    = 0;
  logic [22:0] m_out    = '0;

  function automatic logic [22:0] mk(input logic signed [11:0] x, input logic [10:0] y);
    return {x, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit ie, input logic [22:0] id,
                            input bit is, input logic [22:0] ii, input bit rm);
    logic [22:0] e;
    if (!r) begin
      q.delete();
      m_active = 1'b0;
      m_rem    = 0;
      m_out    = '0;
    end else if (c) begin
      if (!m_active) begin
        if (ie && q.size() < 16) q.push_back(id);
        if (is) begin
          if (q.size() > 0) begin
            m_active = 1'b1;
            m_rem    = q.size();
            m_out    = q[0];
          end else begin
            m_out = '0;
          end
        end
      end else if (is) begin
        m_rem = q.size();
        m_out = q[0];
      end else begin
        e = q.pop_front();
        if (!rm) q.push_back(ii);
        if (m_rem == 1) m_active = 1'b0;
        else begin
          m_rem--;
          m_out = q[0];
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit ie, input logic [22:0] id,
                     input bit is, input logic [22:0] ii, input bit rm);
    rst             = r;
    ce              = c;
    bus.insert_en   = ie;
    bus.insert_data = id;
    bus.iter_start  = is;
    bus.iter_in     = ii;
    bus.iter_remove = rm;
    @(posedge clk);
    model_step(r, c, ie, id, is, ii, rm);
    #1;
    check("count", 32'(bus.count), 32'(q.size()));
    check("iter_done", 32'(bus.iter_done), 32'(!m_active || m_rem == 1));
    check("iter_out", 32'(bus.iter_out), 32'(m_out));
  endtask

  task automatic ins(input logic [22:0] d);  cyc(1, 1, 1, d, 0, '0, 0); endtask
  task automatic start();                    cyc(1, 1, 0, '0, 1, '0, 0); endtask
  task automatic commit(input logic [22:0] d, input bit rm); cyc(1, 1, 0, '0, 0, d, rm); endtask
  task automatic do_reset();                 cyc(0, 1, 0, '0, 0, '0, 0); endtask

  initial begin
    logic [22:0] a, b, c3, frozen_out;
    logic [4:0]  frozen_cnt;
    logic        frozen_done;
    bus.insert_en = 0; bus.insert_data = '0; bus.iter_start = 0;
    bus.iter_in = '0; bus.iter_remove = 0;
    @(negedge clk);

    // Reset, with an insert attempted during reset
    cyc(0, 1, 1, mk(12'sd100, 11'd1), 0, '0, 0);
    cyc(0, 1, 1, mk(12'sd101, 11'd2), 0, '0, 0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_done", 32'(bus.iter_done), 32'd1);
    check("reset_out", 32'(bus.iter_out), 32'd0);

    // Two-element pass and write-back
    ins(mk(12'sd639, 11'd100));
    ins(mk(12'sd489, 11'd50));
    check("two_count", 32'(bus.count), 32'd2);
    start();
    check("first_out", 32'(bus.iter_out), 32'(mk(12'sd639, 11'd100)));
    check("first_done", 32'(bus.iter_done), 32'd0);
    commit(mk(12'sd638, 11'd100), 0);
    check("second_out", 32'(bus.iter_out), 32'(mk(12'sd489, 11'd50)));
    check("second_done", 32'(bus.iter_done), 32'd1);
    commit(mk(12'sd488, 11'd50), 0);
    start();
    check("pass2_first", 32'(bus.iter_out), 32'(mk(12'sd638, 11'd100)));
    commit(bus.iter_out, 0);
    check("pass2_second", 32'(bus.iter_out), 32'(mk(12'sd488, 11'd50)));
    commit(bus.iter_out, 0);

    // Remove the middle one of three
    do_reset();
    a = mk(12'sd10, 11'd1); b = mk(12'sd20, 11'd2); c3 = mk(12'sd30, 11'd3);
    ins(a); ins(b); ins(c3);
    start(); commit(a, 0); commit(b, 1); commit(c3, 0);
    check("remove_count", 32'(bus.count), 32'd2);
    start();
    check("remove_first", 32'(bus.iter_out), 32'(a));
    commit(a, 0);
    check("remove_second", 32'(bus.iter_out), 32'(c3));
    commit(c3, 0);

    // Fill, overflow, full-list write-back pass, then a read pass
    do_reset();
    for (int i = 0; i < 16; i++) ins(23'($urandom));
    ins(mk(-12'sd1, 11'd2047));
    check("full_count", 32'(bus.count), 32'd16);
    start();
    for (int i = 0; i < 16; i++) commit(m_out, 0);
    start();
    for (int i = 0; i < 16; i++) commit(m_out, 0);

    // Empty start, then a negative x round trip; insert+start from empty
    do_reset();
    start();
    check("empty_done", 32'(bus.iter_done), 32'd1);
    check("empty_count", 32'(bus.count), 32'd0);
    cyc(1, 1, 1, mk(-12'sd5, 11'd77), 1, '0, 0);
    a = bus.iter_out;
    check("neg_x", 32'(a[22:11]), 32'h0FFB);
    commit(a, 0);

    // ce freeze mid-iteration, then reset mid-iteration
    do_reset();
    for (int i = 0; i < 4; i++) ins(23'($urandom));
    start(); commit(m_out, 0);
    frozen_out = bus.iter_out; frozen_cnt = bus.count; frozen_done = bus.iter_done;
    for (int i = 0; i < 10; i++)
      cyc(1, 0, $urandom_range(0, 1), 23'($urandom), $urandom_range(0, 1), 23'($urandom),
          $urandom_range(0, 1));
    check("freeze_out", 32'(bus.iter_out), 32'(frozen_out));
    check("freeze_count", 32'(bus.count), 32'(frozen_cnt));
    check("freeze_done", 32'(bus.iter_done), 32'(frozen_done));
    commit(m_out, 0);
    do_reset();
    check("midreset_count", 32'(bus.count), 32'd0);
    check("midreset_done", 32'(bus.iter_done), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, c, ie, is, rm;
      r  = ($urandom_range(0, 199) != 0);
      c  = ($urandom_range(0, 3) != 0);
      ie = ($urandom_range(0, 1) == 1);
      is = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 5) == 0);
      rm = ($urandom_range(0, 4) == 0);
      cyc(r, c, ie, 23'($urandom), is, 23'($urandom), rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
